boot_sequencer: RTL and testbench

Sequences the Lapido pipeline from power-up to execution. It accepts a stream of instruction words from the bios loader, writes them into instruction memory, then drains the pipeline with bubbles, and finally releases the program counter. During execution it owns instruction-memory address/strobe muxing between loader and PC, and gates PC enable with the HDU stall. It replaces the ad-hoc WE/OE/Address/enablePC logic in the top level.

---
 rtl/boot_sequencer.sv | 197 +++++++++++++++++++
 tb/tb_boot_sequencer.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/boot_sequencer.sv
// boot_sequencer: loads an instruction image from the bios loader, drains the pipeline, then releases the PC.
// Optional BOOT_CHECKSUM_EN: the load_last word is a 32-bit wrapping checksum of the image instead of an instruction.
module boot_sequencer #(
    parameter int MEM_WORDS    = 256,
    parameter int FLUSH_CYCLES = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        load_valid,
    input  logic [31:0] load_data,
    input  logic        load_last,
    output logic        load_ready,
    input  logic [31:0] pc_in,
    input  logic        stall_in,
    input  logic        halt_in,
    output logic [31:0] imem_address,
    output logic [31:0] imem_data,
    output logic        imem_we,
    output logic        imem_oe,
    output logic        pc_enable,
    output logic        pipe_flush,
    output logic        regfile_reset,
    output logic        running,
    output logic [15:0] word_count,
    output logic        error
);
    localparam int             FCW        = (FLUSH_CYCLES < 1) ? 1 : $clog2(FLUSH_CYCLES + 1);
    localparam logic [FCW-1:0] FLUSH_INIT = FCW'(FLUSH_CYCLES);
    localparam logic [15:0]    MEM_LIMIT  = 16'(MEM_WORDS);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_FLUSH = 3'd2,
        S_RUN   = 3'd3,
        S_HALT  = 3'd4
    } state_t;

    state_t         state_q, state_d;
    logic [15:0]    wc_q, wc_d;
    logic           err_q, err_d;
    logic           ready_q, ready_d;
    logic           we_q, we_d;
    logic [31:0]    waddr_q, waddr_d;
    logic [31:0]    wdata_q, wdata_d;
    logic           oe_q, oe_d;
    logic           rfrst_q, rfrst_d;
    logic           run_q, run_d;
    logic [FCW-1:0] fcnt_q, fcnt_d;
    logic           accept;
`ifdef BOOT_CHECKSUM_EN
    logic [31:0]    sum_q, sum_d;
`endif

    // State and registered-output flops; reset lands in IDLE with the register file held.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            wc_q    <= 16'd0;
            err_q   <= 1'b0;
            ready_q <= 1'b0;
            we_q    <= 1'b0;
            waddr_q <= 32'd0;
            wdata_q <= 32'd0;
            oe_q    <= 1'b0;
            rfrst_q <= 1'b1;
            run_q   <= 1'b0;
            fcnt_q  <= {FCW{1'b0}};
`ifdef BOOT_CHECKSUM_EN
            sum_q   <= 32'd0;
`endif
        end else begin
            state_q <= state_d;
            wc_q    <= wc_d;
            err_q   <= err_d;
            ready_q <= ready_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            oe_q    <= oe_d;
            rfrst_q <= rfrst_d;
            run_q   <= run_d;
            fcnt_q  <= fcnt_d;
`ifdef BOOT_CHECKSUM_EN
            sum_q   <= sum_d;
`endif
        end
    end

    // Next-state logic and next values of the registered outputs.
    always_comb begin
        state_d = state_q;
        wc_d    = wc_q;
        err_d   = err_q;
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        fcnt_d  = fcnt_q;
`ifdef BOOT_CHECKSUM_EN
        sum_d   = sum_q;
`endif
        // ready_q already encodes "in LOAD with room left", so no extra state term is needed
        accept  = (state_q == S_LOAD) && load_valid && ready_q;

        case (state_q)
            S_IDLE, S_HALT: begin
                if (start) begin
                    state_d = S_LOAD;
                    wc_d    = 16'd0;
                    err_d   = 1'b0;
`ifdef BOOT_CHECKSUM_EN
                    sum_d   = 32'd0;
`endif
                end else begin
                    state_d = state_q;
                end
            end
            S_LOAD: begin
                if (accept) begin
`ifdef BOOT_CHECKSUM_EN
                    if (load_last) begin
                        if (load_data == sum_q) begin
                            state_d = S_FLUSH;
                            fcnt_d  = FLUSH_INIT;
                        end else begin
                            err_d   = 1'b1;
                            state_d = S_HALT;
                        end
                    end else begin
                        we_d    = 1'b1;
                        waddr_d = {16'd0, wc_q};
                        wdata_d = load_data;
                        wc_d    = wc_q + 16'd1;
                        sum_d   = sum_q + load_data;
                    end
`else
                    we_d    = 1'b1;
                    waddr_d = {16'd0, wc_q};
                    wdata_d = load_data;
                    wc_d    = wc_q + 16'd1;
                    if (load_last) begin
                        state_d = S_FLUSH;
                        fcnt_d  = FLUSH_INIT;
                    end else begin
                        state_d = S_LOAD;
                    end
`endif
                end else if (load_valid && (wc_q == MEM_LIMIT)) begin
                    // image larger than memory: drop the word and stop
                    err_d   = 1'b1;
                    state_d = S_HALT;
                end else begin
                    state_d = S_LOAD;
                end
            end
            S_FLUSH: begin
                if (fcnt_q == {FCW{1'b0}}) begin
                    state_d = S_RUN;
                end else begin
                    fcnt_d  = fcnt_q - {{(FCW-1){1'b0}}, 1'b1};
                end
            end
            S_RUN: begin
                if (halt_in) begin
                    state_d = S_HALT;
                end else begin
                    state_d = S_RUN;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        ready_d = (state_d == S_LOAD) && (wc_d < MEM_LIMIT);
        oe_d    = (state_d == S_FLUSH) || (state_d == S_RUN);
        rfrst_d = (state_d == S_IDLE) || (state_d == S_LOAD);
        run_d   = (state_d == S_RUN);
    end

    // The final loader write overlaps the first FLUSH cycle, so it keeps the address bus for that cycle.
    assign imem_address  = (oe_q && !we_q) ? pc_in : waddr_q;
    assign imem_data     = wdata_q;
    assign imem_we       = we_q;
    assign imem_oe       = oe_q;
    assign load_ready    = ready_q;
    assign regfile_reset = rfrst_q;
    assign running       = run_q;
    assign word_count    = wc_q;
    assign error         = err_q;

    // Stalls must hit the PC in the same cycle, so these two follow stall_in directly in RUN.
    assign pc_enable  = (state_q == S_RUN) ? ~stall_in : 1'b0;
    assign pipe_flush = (state_q == S_RUN) ? stall_in : 1'b1;

endmodule

// File: tb/tb_boot_sequencer.sv
// Self-checking bench for boot_sequencer: randomized images checked against a word-level load/flush/run model.
module tb_boot_sequencer;
    localparam int MEMW = 4;
    localparam int FLC  = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        load_valid = 1'b0;
    logic [31:0] load_data = 32'd0;
    logic        load_last = 1'b0;
    logic [31:0] pc_in = 32'd0;
    logic        stall_in = 1'b0;
    logic        halt_in = 1'b0;
    logic        load_ready, imem_we, imem_oe, pc_enable, pipe_flush, regfile_reset, running, error;
    logic [31:0] imem_address, imem_data;
    logic [15:0] word_count;

    int total = 0;
    int bad = 0;
    logic [31:0] img [0:7];
    int gap [0:7];
    int outcome;   // 0 still loading, 1 reached RUN, 2 halted
    int exp_wc;

    always #5 clock = ~clock;

    boot_sequencer #(.MEM_WORDS(MEMW), .FLUSH_CYCLES(FLC)) dut (
        .clock(clock), .reset(reset), .start(start), .load_valid(load_valid),
        .load_data(load_data), .load_last(load_last), .load_ready(load_ready),
        .pc_in(pc_in), .stall_in(stall_in), .halt_in(halt_in),
        .imem_address(imem_address), .imem_data(imem_data), .imem_we(imem_we),
        .imem_oe(imem_oe), .pc_enable(pc_enable), .pipe_flush(pipe_flush),
        .regfile_reset(regfile_reset), .running(running), .word_count(word_count),
        .error(error)
    );

    function automatic logic [7:0] flags();
        return {load_ready, imem_we, imem_oe, pc_enable, running, error, regfile_reset, pipe_flush};
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_gaps();
        for (int i = 0; i < 8; i++) gap[i] = 0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #12;
        total++;
        if ({flags(), word_count, imem_address, imem_data} !== {8'b0000_0011, 16'd0, 32'd0, 32'd0}) begin
            bad++;
            $display("FAIL reset_values got flags=%b wc=%0d addr=%h data=%h want flags=00000011 wc=0 addr=0 data=0",
                     flags(), word_count, imem_address, imem_data);
        end
        @(negedge clock);
        reset = 1'b0;
    endtask

    // Loads img[0..n-1]; the model accepts one word per valid cycle while fewer than MEMW words are stored.
    task automatic load_image(input int n, input bit use_last);
        logic [31:0] csum;
        bit halted;
        csum = 32'd0; exp_wc = 0; outcome = 0; halted = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        total++;
        if ({word_count, error, load_ready, regfile_reset, running} !== {16'd0, 1'b0, 1'b1, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL load_start got wc=%0d err=%0b rdy=%0b rfr=%0b run=%0b want wc=0 err=0 rdy=1 rfr=1 run=0",
                     word_count, error, load_ready, regfile_reset, running);
        end
        for (int i = 0; i < n && !halted; i++) begin
            for (int g = 0; g < gap[i]; g++) begin
                load_valid = 1'b0;
                tick();
                total++;
                if (imem_we !== 1'b0 || word_count !== 16'(exp_wc)) begin
                    bad++;
                    $display("FAIL gap_idle got we=%0b wc=%0d want we=0 wc=%0d", imem_we, word_count, exp_wc);
                end
            end
            load_valid = 1'b1;
            load_data  = img[i];
            load_last  = use_last && (i == n - 1);
            tick();
            if (exp_wc == MEMW) begin
                halted = 1'b1; outcome = 2;
                total++;
                if ({imem_we, error, load_ready, running, imem_oe, pipe_flush} !== 6'b010001) begin
                    bad++;
                    $display("FAIL overflow got we=%0b err=%0b rdy=%0b run=%0b oe=%0b flush=%0b want 0 1 0 0 0 1",
                             imem_we, error, load_ready, running, imem_oe, pipe_flush);
                end
            end
`ifdef BOOT_CHECKSUM_EN
            else if (load_last) begin
                total++;
                if (imem_we !== 1'b0) begin
                    bad++;
                    $display("FAIL cksum_nowrite got we=%0b want we=0", imem_we);
                end
                if (img[i] == csum) begin
                    outcome = 1;
                end else begin
                    outcome = 2; halted = 1'b1;
                    total++;
                    if ({error, load_ready, imem_oe, running} !== 4'b1000) begin
                        bad++;
                        $display("FAIL cksum_bad got err=%0b rdy=%0b oe=%0b run=%0b want 1 0 0 0",
                                 error, load_ready, imem_oe, running);
                    end
                end
            end
`endif
            else begin
                total++;
                if ({imem_we, imem_address, imem_data} !== {1'b1, 32'(exp_wc), img[i]}) begin
                    bad++;
                    $display("FAIL write got we=%0b addr=%h data=%h want we=1 addr=%h data=%h",
                             imem_we, imem_address, imem_data, 32'(exp_wc), img[i]);
                end
                csum = csum + img[i];
                exp_wc++;
                if (load_last) outcome = 1;
            end
            total++;
            if (word_count !== 16'(exp_wc)) begin
                bad++;
                $display("FAIL word_count got %0d want %0d", word_count, exp_wc);
            end
            if (outcome == 0) begin
                total++;
                if (load_ready !== ((exp_wc < MEMW) ? 1'b1 : 1'b0)) begin
                    bad++;
                    $display("FAIL load_ready got %0b want %0b", load_ready, (exp_wc < MEMW));
                end
            end
        end
        load_valid = 1'b0;
        load_last  = 1'b0;
        if (outcome == 1) begin
            total++;
            if ({regfile_reset, imem_oe, pc_enable, pipe_flush, running} !== 5'b01010) begin
                bad++;
                $display("FAIL flush_entry got rfr=%0b oe=%0b pce=%0b flush=%0b run=%0b want 0 1 0 1 0",
                         regfile_reset, imem_oe, pc_enable, pipe_flush, running);
            end
            for (int c = 1; c <= FLC + 1; c++) begin
                pc_in = $urandom;
                tick();
                total++;
                if ({pc_enable, running, pipe_flush, imem_oe, imem_we, imem_address} !==
                    {(c == FLC + 1) ? 2'b11 : 2'b00, (c <= FLC) ? 1'b1 : 1'b0, 1'b1, 1'b0, pc_in}) begin
                    bad++;
                    $display("FAIL flush_cycle%0d got pce=%0b run=%0b flush=%0b oe=%0b we=%0b addr=%h pc=%h",
                             c, pc_enable, running, pipe_flush, imem_oe, imem_we, imem_address, pc_in);
                end
            end
        end
    endtask

    task automatic go_halt();
        halt_in = 1'b1;
        tick();
        halt_in = 1'b0;
        total++;
        if ({running, pc_enable, pipe_flush, imem_oe} !== 4'b0010) begin
            bad++;
            $display("FAIL halt got run=%0b pce=%0b flush=%0b oe=%0b want 0 0 1 0",
                     running, pc_enable, pipe_flush, imem_oe);
        end
    endtask

    task automatic test_basic();
        clear_gaps();
        img[0] = 32'h11; img[1] = 32'h22; img[2] = 32'h33;
        load_image(3, 1'b1);
        if (outcome == 1) go_halt();
    endtask

    task automatic test_gap();
        clear_gaps();
        for (int i = 0; i < 4; i++) img[i] = $urandom;
        gap[2] = 2;
        load_image(4, 1'b1);
        if (outcome == 1) go_halt();
    endtask

    task automatic test_overflow();
        clear_gaps();
        for (int i = 0; i < 5; i++) img[i] = $urandom;
        load_image(5, 1'b0);
        tick();
        total++;
        if ({load_ready, error, running, word_count} !== {1'b0, 1'b1, 1'b0, 16'(MEMW)}) begin
            bad++;
            $display("FAIL overflow_hold got rdy=%0b err=%0b run=%0b wc=%0d want 0 1 0 %0d",
                     load_ready, error, running, word_count, MEMW);
        end
    endtask

    task automatic test_stall_halt();
        clear_gaps();
        img[0] = 32'd1; img[1] = 32'd2; img[2] = 32'd3;
        load_image(3, 1'b1);
        stall_in = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        total++;
        if ({running, pc_enable, pipe_flush} !== 3'b110) begin
            bad++;
            $display("FAIL run_ignore_start got run=%0b pce=%0b flush=%0b want 1 1 0", running, pc_enable, pipe_flush);
        end
        stall_in = 1'b1;
        #1;
        total++;
        if ({pc_enable, pipe_flush} !== 2'b01) begin
            bad++;
            $display("FAIL stall_now got pce=%0b flush=%0b want 0 1", pc_enable, pipe_flush);
        end
        tick();
        total++;
        if ({running, pc_enable, pipe_flush} !== 3'b101) begin
            bad++;
            $display("FAIL stall_hold got run=%0b pce=%0b flush=%0b want 1 0 1", running, pc_enable, pipe_flush);
        end
        halt_in = 1'b1;
        tick();
        halt_in = 1'b0; stall_in = 1'b0;
        total++;
        if ({running, pc_enable, pipe_flush, imem_oe} !== 4'b0010) begin
            bad++;
            $display("FAIL halt_wins got run=%0b pce=%0b flush=%0b oe=%0b want 0 0 1 0",
                     running, pc_enable, pipe_flush, imem_oe);
        end
        tick();
        total++;
        if ({running, pc_enable} !== 2'b00) begin
            bad++;
            $display("FAIL halt_sticky got run=%0b pce=%0b want 0 0", running, pc_enable);
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 8; it++) begin
            int n;
            logic [31:0] s;
            clear_gaps();
            n = $urandom_range(1, MEMW);
            s = 32'd0;
            for (int i = 0; i < n; i++) begin
                img[i] = $urandom;
                gap[i] = $urandom_range(0, 2);
                if (i < n - 1) s = s + img[i];
            end
`ifdef BOOT_CHECKSUM_EN
            if ($urandom_range(0, 1) == 1) img[n-1] = s;
`endif
            load_image(n, 1'b1);
            if (outcome == 1) begin
                for (int c = 0; c < 4; c++) begin
                    stall_in = ($urandom_range(0, 1) == 1);
                    pc_in = $urandom;
                    #1;
                    total++;
                    if ({pc_enable, pipe_flush, imem_address} !== {~stall_in, stall_in, pc_in}) begin
                        bad++;
                        $display("FAIL run_stall got pce=%0b flush=%0b addr=%h want pce=%0b flush=%0b addr=%h",
                                 pc_enable, pipe_flush, imem_address, ~stall_in, stall_in, pc_in);
                    end
                    tick();
                end
                stall_in = 1'b0;
                go_halt();
            end
        end
    endtask

    task automatic test_reset_mid_load();
        clear_gaps();
        start = 1'b1;
        tick();
        start = 1'b0;
        load_valid = 1'b1; load_data = 32'hA5A5_0001;
        tick();
        load_data = 32'hA5A5_0002;
        #2;
        reset = 1'b1;
        #1;
        total++;
        if ({flags(), word_count} !== {8'b0000_0011, 16'd0}) begin
            bad++;
            $display("FAIL reset_async got flags=%b wc=%0d want flags=00000011 wc=0", flags(), word_count);
        end
        #2;
        reset = 1'b0;
        load_valid = 1'b0;
        tick();
        total++;
        if ({imem_we, load_ready, running} !== 3'b000) begin
            bad++;
            $display("FAIL post_reset_idle got we=%0b rdy=%0b run=%0b want 0 0 0", imem_we, load_ready, running);
        end
        img[0] = 32'hC0DE_0000; img[1] = 32'hC0DE_0001; img[2] = 32'h8180_0001;
        load_image(3, 1'b1);
        if (outcome == 1) go_halt();
    endtask

`ifdef BOOT_CHECKSUM_EN
    task automatic test_checksum();
        clear_gaps();
        img[0] = 32'd1; img[1] = 32'd2; img[2] = 32'd3;
        load_image(3, 1'b1);
        total++;
        if ({running, error, word_count} !== {1'b1, 1'b0, 16'd2}) begin
            bad++;
            $display("FAIL cksum_ok got run=%0b err=%0b wc=%0d want 1 0 2", running, error, word_count);
        end
        go_halt();
        img[2] = 32'd4;
        load_image(3, 1'b1);
        total++;
        if ({running, error, word_count} !== {1'b0, 1'b1, 16'd2}) begin
            bad++;
            $display("FAIL cksum_mismatch got run=%0b err=%0b wc=%0d want 0 1 2", running, error, word_count);
        end
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_gap();
        test_overflow();
        test_stall_halt();
        test_reset_mid_load();
        test_random();
`ifdef BOOT_CHECKSUM_EN
        test_checksum();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
